// File: rtl/rv32i_muldiv_pkg.sv
// Shared opcodes, FSM encoding and build options for the M-extension multiply/divide unit.
// Build option: MULDIV_FAST_MUL_EN selects a single-cycle multiplier for MUL/MULH/MULHSU/MULHU.
package rv32i_muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FIXUP = 2'd2
    } state_e;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST_MUL_EN = 1'b1;
`else
    localparam bit FAST_MUL_EN = 1'b0;
`endif

    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic rs1_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic rs2_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/rv32i_muldiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface rv32i_muldiv_if #(
    parameter int XLEN = 32
);
    logic            i_ce;
    logic            i_start;
    logic [2:0]      i_funct3;
    logic [XLEN-1:0] i_rs1;
    logic [XLEN-1:0] i_rs2;
    logic [4:0]      i_rd_addr;
    logic            i_flush;
    logic [XLEN-1:0] o_y;
    logic [4:0]      o_rd_addr;
    logic            o_done;
    logic            o_stall;

    modport master (
        output i_ce, i_start, i_funct3, i_rs1, i_rs2, i_rd_addr, i_flush,
        input  o_y, o_rd_addr, o_done, o_stall
    );

    modport slave (
        input  i_ce, i_start, i_funct3, i_rs1, i_rs2, i_rd_addr, i_flush,
        output o_y, o_rd_addr, o_done, o_stall
    );
endinterface

// File: rtl/rv32i_muldiv_step.sv
// One iteration of the shared {hi,lo} datapath: restoring-divide step or shift-add multiply step.
module rv32i_muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            mode_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] opnd,
    output logic [XLEN-1:0] hi_nxt,
    output logic [XLEN-1:0] lo_nxt
);
    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Divide: hi is the partial remainder, lo shifts the dividend out and the quotient in.
    // Multiply: lo holds the multiplier, the product shifts down through {hi,lo}.
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, opnd};
        if (mode_div) begin
            hi_nxt = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], ~diff[XLEN]};
        end else begin
            hi_nxt = sum[XLEN:1];
            lo_nxt = {sum[0], lo[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/rv32i_muldiv.sv
// Iterative RV M-extension execute unit; divide-by-zero and signed overflow finish in one cycle.
// Build option: MULDIV_FAST_MUL_EN moves all multiplies onto the single-cycle path.
module rv32i_muldiv
    import rv32i_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    rv32i_muldiv_if.slave bus
);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v, input logic en);
        return en ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_dw(input logic [2*XLEN-1:0] v, input logic en);
        return en ? (~v + {{(2*XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, lo_q, opnd_q;
    logic [XLEN-1:0]   hi_nxt, lo_nxt;
    logic [2:0]        f3_q;
    logic              neg_q;
    logic [4:0]        tag_q;
    logic [XLEN-1:0]   y_q;
    logic [4:0]        rd_q;
    logic              done_q;

    logic              accept, is_div, rs1_neg, rs2_neg, neg_in;
    logic              div_zero, div_ovf, fast_mul, fast;
    logic [XLEN-1:0]   mag1, mag2, fast_y, fix_y;
    logic [2*XLEN-1:0] prod_fix;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
`endif

    always_comb begin
        is_div   = is_div_op(bus.i_funct3);
        rs1_neg  = rs1_is_signed(bus.i_funct3) && bus.i_rs1[XLEN-1];
        rs2_neg  = rs2_is_signed(bus.i_funct3) && bus.i_rs2[XLEN-1];
        mag1     = neg_w(bus.i_rs1, rs1_neg);
        mag2     = neg_w(bus.i_rs2, rs2_neg);
        // Remainder follows the dividend; quotient and product follow the sign difference.
        neg_in   = (is_div && bus.i_funct3[1]) ? rs1_neg : (rs1_neg ^ rs2_neg);
        div_zero = is_div && (bus.i_rs2 == '0);
        div_ovf  = is_div && !bus.i_funct3[0] && (bus.i_rs1 == MIN_INT) && (&bus.i_rs2);
`ifdef MULDIV_FAST_MUL_EN
        fast_mul = !is_div;
`else
        fast_mul = 1'b0;
`endif
        fast     = div_zero || div_ovf || fast_mul;
        accept   = (state_q == ST_IDLE) && bus.i_ce && bus.i_start && !bus.i_flush;

        fast_y = '0;
        if (div_zero) begin
            fast_y = bus.i_funct3[1] ? bus.i_rs1 : '1;
        end else if (div_ovf) begin
            fast_y = bus.i_funct3[1] ? '0 : bus.i_rs1;
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (fast_mul) begin
            fast_y = (bus.i_funct3 == F3_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
        end
`endif
    end

`ifdef MULDIV_FAST_MUL_EN
    assign fast_prod = neg_dw({{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2}, neg_in);
`endif

    always_comb begin
        prod_fix = neg_dw({hi_q, lo_q}, neg_q);
        if (is_div_op(f3_q)) begin
            fix_y = f3_q[1] ? neg_w(hi_q, neg_q) : neg_w(lo_q, neg_q);
        end else begin
            fix_y = (f3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.i_flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && !fast) begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_W'(XLEN);
                    end
                end
                ST_BUSY: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state_d = ST_FIXUP;
                end
                ST_FIXUP: state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    rv32i_muldiv_step #(.XLEN(XLEN)) u_step (
        .mode_div (f3_q[2]),
        .hi       (hi_q),
        .lo       (lo_q),
        .opnd     (opnd_q),
        .hi_nxt   (hi_nxt),
        .lo_nxt   (lo_nxt)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            y_q     <= '0;
            rd_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= 1'b0;
            if (accept && fast) begin
                y_q    <= fast_y;
                rd_q   <= bus.i_rd_addr;
                done_q <= 1'b1;
            end else if (state_q == ST_FIXUP && !bus.i_flush) begin
                y_q    <= fix_y;
                rd_q   <= tag_q;
                done_q <= 1'b1;
            end
        end
    end

    // Operand/accumulator registers: loaded at acceptance, stepped while BUSY.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            hi_q   <= '0;
            lo_q   <= is_div ? mag1 : mag2;
            opnd_q <= is_div ? mag2 : mag1;
            f3_q   <= bus.i_funct3;
            neg_q  <= neg_in;
            tag_q  <= bus.i_rd_addr;
        end else if (state_q == ST_BUSY) begin
            hi_q <= hi_nxt;
            lo_q <= lo_nxt;
        end
    end

    assign bus.o_y       = y_q;
    assign bus.o_rd_addr = rd_q;
    assign bus.o_done    = done_q;
    assign bus.o_stall   = !bus.i_flush &&
                           ((state_q != ST_IDLE) || (bus.i_ce && bus.i_start && !fast));
endmodule
